// File: rtl/tl_width_downsizer.sv
`default_nettype none
// ============================================================================
// Module      : tl_width_downsizer
// Description : TileLink-UL width adapter between a wide upstream client port
//               (IN_BYTES per beat) and a narrow downstream manager port
//               (OUT_BYTES per beat).
//               A channel: each wide beat is split into up to RATIO narrow beats
//               with zero latency and no buffering (the upstream beat is held
//               stable by the protocol while it is being split).
//               D channel: narrow response beats are merged back into wide
//               beats; all but the final narrow beat of a group are absorbed
//               into an accumulator, and the final one is forwarded upstream
//               together with the stored slices.
//               RATIO = IN_BYTES/OUT_BYTES; RATIO=1 is a plain wire.
// Ports       : clock, reset               - shared clock, async active-high reset
//               auto_in_a_*                 - upstream A (wide, this block is sink)
//               auto_in_d_*                 - upstream D (wide, this block is source)
//               auto_out_a_*                - downstream A (narrow, this block is source)
//               auto_out_d_*                - downstream D (narrow, this block is sink)
// Revision    : 1.0 - initial release
// ============================================================================
module tl_width_downsizer #(
   parameter int IN_BYTES  = 8,
   parameter int OUT_BYTES = 4,
   parameter int ADDR_W    = 32,
   parameter int SRC_W     = 1,
   parameter int SINK_W    = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   // upstream A
   output logic                   auto_in_a_ready,
   input  logic                   auto_in_a_valid,
   input  logic [2:0]             auto_in_a_bits_opcode,
   input  logic [2:0]             auto_in_a_bits_param,
   input  logic [3:0]             auto_in_a_bits_size,
   input  logic [SRC_W-1:0]       auto_in_a_bits_source,
   input  logic [ADDR_W-1:0]      auto_in_a_bits_address,
   input  logic [IN_BYTES-1:0]    auto_in_a_bits_mask,
   input  logic [8*IN_BYTES-1:0]  auto_in_a_bits_data,
   input  logic                   auto_in_a_bits_corrupt,
   // upstream D
   input  logic                   auto_in_d_ready,
   output logic                   auto_in_d_valid,
   output logic [2:0]             auto_in_d_bits_opcode,
   output logic [1:0]             auto_in_d_bits_param,
   output logic [3:0]             auto_in_d_bits_size,
   output logic [SRC_W-1:0]       auto_in_d_bits_source,
   output logic [SINK_W-1:0]      auto_in_d_bits_sink,
   output logic                   auto_in_d_bits_denied,
   output logic [8*IN_BYTES-1:0]  auto_in_d_bits_data,
   output logic                   auto_in_d_bits_corrupt,
   // downstream A
   input  logic                   auto_out_a_ready,
   output logic                   auto_out_a_valid,
   output logic [2:0]             auto_out_a_bits_opcode,
   output logic [2:0]             auto_out_a_bits_param,
   output logic [3:0]             auto_out_a_bits_size,
   output logic [SRC_W-1:0]       auto_out_a_bits_source,
   output logic [ADDR_W-1:0]      auto_out_a_bits_address,
   output logic [OUT_BYTES-1:0]   auto_out_a_bits_mask,
   output logic [8*OUT_BYTES-1:0] auto_out_a_bits_data,
   output logic                   auto_out_a_bits_corrupt,
   // downstream D
   output logic                   auto_out_d_ready,
   input  logic                   auto_out_d_valid,
   input  logic [2:0]             auto_out_d_bits_opcode,
   input  logic [1:0]             auto_out_d_bits_param,
   input  logic [3:0]             auto_out_d_bits_size,
   input  logic [SRC_W-1:0]       auto_out_d_bits_source,
   input  logic [SINK_W-1:0]      auto_out_d_bits_sink,
   input  logic                   auto_out_d_bits_denied,
   input  logic [8*OUT_BYTES-1:0] auto_out_d_bits_data,
   input  logic                   auto_out_d_bits_corrupt
);

   localparam int c_ratio    = IN_BYTES / OUT_BYTES;
   localparam int c_ratio_lg = $clog2(c_ratio);
   localparam int c_ib_lg    = $clog2(IN_BYTES);
   localparam int c_ob_lg    = $clog2(OUT_BYTES);
   localparam int c_out_w    = 8 * OUT_BYTES;

   localparam logic [2:0] c_op_put_full    = 3'd0;
   localparam logic [2:0] c_op_put_partial = 3'd1;
   localparam logic [2:0] c_op_ack_data    = 3'd1;

   // Fields that pass through unchanged regardless of ratio
   assign auto_out_a_valid        = auto_in_a_valid;
   assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
   assign auto_out_a_bits_param   = auto_in_a_bits_param;
   assign auto_out_a_bits_size    = auto_in_a_bits_size;
   assign auto_out_a_bits_source  = auto_in_a_bits_source;
   assign auto_out_a_bits_address = auto_in_a_bits_address;
   assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

   // D header fields always come from the beat currently presented
   // downstream, which is the final beat whenever in_d_valid is high.
   assign auto_in_d_bits_opcode   = auto_out_d_bits_opcode;
   assign auto_in_d_bits_param    = auto_out_d_bits_param;
   assign auto_in_d_bits_size     = auto_out_d_bits_size;
   assign auto_in_d_bits_source   = auto_out_d_bits_source;
   assign auto_in_d_bits_sink     = auto_out_d_bits_sink;

   generate
      if (c_ratio == 1) begin : g_passthru
         assign auto_in_a_ready        = auto_out_a_ready;
         assign auto_out_a_bits_mask   = auto_in_a_bits_mask;
         assign auto_out_a_bits_data   = auto_in_a_bits_data;
         assign auto_out_d_ready       = auto_in_d_ready;
         assign auto_in_d_valid        = auto_out_d_valid;
         assign auto_in_d_bits_denied  = auto_out_d_bits_denied;
         assign auto_in_d_bits_data    = auto_out_d_bits_data;
         assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt;
      end else begin : g_split
         localparam int CW = c_ratio_lg;

         // ------------------------------------------------------------------
         // A channel split
         // ------------------------------------------------------------------
         logic [CW-1:0] r_a_cnt;
         logic [3:0]    w_a_lg;     // log2 of narrow beats for this wide beat
         logic [CW-1:0] w_a_max;    // nA-1
         logic [CW-1:0] w_a_sel;
         logic          w_a_last;
         logic          w_a_fire;

         always_comb begin
            w_a_lg = 4'd0;
            if ((auto_in_a_bits_opcode == c_op_put_full ||
                 auto_in_a_bits_opcode == c_op_put_partial) &&
                auto_in_a_bits_size > 4'(c_ob_lg)) begin
               w_a_lg = auto_in_a_bits_size - 4'(c_ob_lg);
               if (w_a_lg > 4'(CW))
                  w_a_lg = 4'(CW);
            end
            w_a_max = CW'((32'd1 << w_a_lg) - 32'd1);
         end

         // The address picks the starting lane for sub-width transfers; the
         // counter walks the remaining lanes of an aligned group.
         assign w_a_sel  = auto_in_a_bits_address[c_ib_lg-1:c_ob_lg] | r_a_cnt;
         assign w_a_last = (r_a_cnt == w_a_max);
         assign w_a_fire = auto_in_a_valid && auto_out_a_ready;

         assign auto_out_a_bits_data = auto_in_a_bits_data[32'(w_a_sel)*c_out_w +: c_out_w];
         assign auto_out_a_bits_mask = auto_in_a_bits_mask[32'(w_a_sel)*OUT_BYTES +: OUT_BYTES];
         assign auto_in_a_ready      = auto_out_a_ready && w_a_last;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_a_cnt <= '0;
            end else if (w_a_fire) begin
               r_a_cnt <= w_a_last ? '0 : r_a_cnt + 1'b1;
            end
         end

         // ------------------------------------------------------------------
         // D channel merge
         // ------------------------------------------------------------------
         logic [CW-1:0]                      r_d_cnt;
         logic [c_ratio-2:0][c_out_w-1:0]    r_d_acc;
         logic                               r_d_corrupt_acc;
         logic                               r_d_denied_acc;
         logic [3:0]                         w_d_lg;
         logic [CW-1:0]                      w_d_max;    // nD-1
         logic                               w_d_last;
         logic                               w_d_fire;
         logic [8*IN_BYTES-1:0]              w_d_data;

         always_comb begin
            w_d_lg = 4'd0;
            if (auto_out_d_bits_opcode == c_op_ack_data &&
                auto_out_d_bits_size > 4'(c_ob_lg)) begin
               w_d_lg = auto_out_d_bits_size - 4'(c_ob_lg);
               if (w_d_lg > 4'(CW))
                  w_d_lg = 4'(CW);
            end
            w_d_max = CW'((32'd1 << w_d_lg) - 32'd1);
         end

         assign w_d_last = (r_d_cnt == w_d_max);
         assign w_d_fire = auto_out_d_valid && auto_out_d_ready;

         // Each wide lane i takes group slot (i mod nD): the incoming beat
         // for the current slot, stored slices for earlier ones. For groups
         // narrower than the wide beat this replicates the group across it.
         always_comb begin
            logic [CW-1:0] j;
            w_d_data = '0;
            for (int i = 0; i < c_ratio; i++) begin
               j = CW'(i) & w_d_max;
               if (j == r_d_cnt)
                  w_d_data[i*c_out_w +: c_out_w] = auto_out_d_bits_data;
               else if (j < CW'(c_ratio - 1))
                  w_d_data[i*c_out_w +: c_out_w] = r_d_acc[j];
            end
         end

         assign auto_out_d_ready       = w_d_last ? auto_in_d_ready : 1'b1;
         assign auto_in_d_valid        = auto_out_d_valid && w_d_last;
         assign auto_in_d_bits_data    = w_d_data;
         assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt | r_d_corrupt_acc;
         assign auto_in_d_bits_denied  = auto_out_d_bits_denied  | r_d_denied_acc;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_d_cnt         <= '0;
               r_d_acc         <= '0;
               r_d_corrupt_acc <= 1'b0;
               r_d_denied_acc  <= 1'b0;
            end else if (w_d_fire) begin
               if (w_d_last) begin
                  r_d_cnt         <= '0;
                  r_d_acc         <= '0;
                  r_d_corrupt_acc <= 1'b0;
                  r_d_denied_acc  <= 1'b0;
               end else begin
                  r_d_acc[r_d_cnt] <= auto_out_d_bits_data;
                  r_d_corrupt_acc  <= r_d_corrupt_acc | auto_out_d_bits_corrupt;
                  r_d_denied_acc   <= r_d_denied_acc  | auto_out_d_bits_denied;
                  r_d_cnt          <= r_d_cnt + 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tl_width_downsizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_width_downsizer
// Description : Directed testbench for tl_width_downsizer at IN_BYTES=8,
//               OUT_BYTES=4 (RATIO=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_width_downsizer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        in_a_ready;
   logic        in_a_valid = 1'b0;
   logic [2:0]  in_a_opcode = 3'd0;
   logic [2:0]  in_a_param = 3'd0;
   logic [3:0]  in_a_size = 4'd0;
   logic [0:0]  in_a_source = 1'b0;
   logic [31:0] in_a_address = 32'd0;
   logic [7:0]  in_a_mask = 8'd0;
   logic [63:0] in_a_data = 64'd0;
   logic        in_a_corrupt = 1'b0;

   logic        in_d_ready = 1'b1;
   logic        in_d_valid;
   logic [2:0]  in_d_opcode;
   logic [1:0]  in_d_param;
   logic [3:0]  in_d_size;
   logic [0:0]  in_d_source;
   logic [1:0]  in_d_sink;
   logic        in_d_denied;
   logic [63:0] in_d_data;
   logic        in_d_corrupt;

   logic        out_a_ready = 1'b1;
   logic        out_a_valid;
   logic [2:0]  out_a_opcode;
   logic [2:0]  out_a_param;
   logic [3:0]  out_a_size;
   logic [0:0]  out_a_source;
   logic [31:0] out_a_address;
   logic [3:0]  out_a_mask;
   logic [31:0] out_a_data;
   logic        out_a_corrupt;

   logic        out_d_ready;
   logic        out_d_valid = 1'b0;
   logic [2:0]  out_d_opcode = 3'd0;
   logic [1:0]  out_d_param = 2'd0;
   logic [3:0]  out_d_size = 4'd0;
   logic [0:0]  out_d_source = 1'b0;
   logic [1:0]  out_d_sink = 2'd0;
   logic        out_d_denied = 1'b0;
   logic [31:0] out_d_data = 32'd0;
   logic        out_d_corrupt = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   tl_width_downsizer #(
      .IN_BYTES(8), .OUT_BYTES(4), .ADDR_W(32), .SRC_W(1), .SINK_W(2)
   ) dut (
      .clock(clock), .reset(reset),
      .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid),
      .auto_in_a_bits_opcode(in_a_opcode), .auto_in_a_bits_param(in_a_param),
      .auto_in_a_bits_size(in_a_size), .auto_in_a_bits_source(in_a_source),
      .auto_in_a_bits_address(in_a_address), .auto_in_a_bits_mask(in_a_mask),
      .auto_in_a_bits_data(in_a_data), .auto_in_a_bits_corrupt(in_a_corrupt),
      .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
      .auto_in_d_bits_opcode(in_d_opcode), .auto_in_d_bits_param(in_d_param),
      .auto_in_d_bits_size(in_d_size), .auto_in_d_bits_source(in_d_source),
      .auto_in_d_bits_sink(in_d_sink), .auto_in_d_bits_denied(in_d_denied),
      .auto_in_d_bits_data(in_d_data), .auto_in_d_bits_corrupt(in_d_corrupt),
      .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
      .auto_out_a_bits_opcode(out_a_opcode), .auto_out_a_bits_param(out_a_param),
      .auto_out_a_bits_size(out_a_size), .auto_out_a_bits_source(out_a_source),
      .auto_out_a_bits_address(out_a_address), .auto_out_a_bits_mask(out_a_mask),
      .auto_out_a_bits_data(out_a_data), .auto_out_a_bits_corrupt(out_a_corrupt),
      .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
      .auto_out_d_bits_opcode(out_d_opcode), .auto_out_d_bits_param(out_d_param),
      .auto_out_d_bits_size(out_d_size), .auto_out_d_bits_source(out_d_source),
      .auto_out_d_bits_sink(out_d_sink), .auto_out_d_bits_denied(out_d_denied),
      .auto_out_d_bits_data(out_d_data), .auto_out_d_bits_corrupt(out_d_corrupt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one narrow D beat on the next negative edge.
   task automatic drive_d(input logic v, input logic [2:0] op, input logic [3:0] sz,
                          input logic [31:0] dat, input logic cor, input logic den,
                          input logic [1:0] snk);
      @(negedge clock);
      out_d_valid   = v;
      out_d_opcode  = op;
      out_d_size    = sz;
      out_d_data    = dat;
      out_d_corrupt = cor;
      out_d_denied  = den;
      out_d_sink    = snk;
      #1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      #2;
      check("rst_out_a_valid", {63'd0, out_a_valid}, 64'd0);
      check("rst_in_d_valid",  {63'd0, in_d_valid},  64'd0);
      check("rst_out_d_ready", {63'd0, out_d_ready}, 64'd1);
      check("rst_in_a_ready",  {63'd0, in_a_ready},  64'd1);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // ---------------- PutFull size 3, split into two beats ----------------
      @(negedge clock);
      out_a_ready  = 1'b0;
      in_a_valid   = 1'b1;
      in_a_opcode  = 3'd0;
      in_a_size    = 4'd3;
      in_a_address = 32'h100;
      in_a_mask    = 8'hFF;
      in_a_data    = 64'h1122334455667788;
      #1;
      check("put_stall_in_a_ready", {63'd0, in_a_ready}, 64'd0);
      check("put_stall_data0",      {32'd0, out_a_data}, 64'h55667788);
      @(negedge clock);            // stalled cycle must not advance the split
      out_a_ready = 1'b1;
      #1;
      check("put_b0_valid",      {63'd0, out_a_valid},  64'd1);
      check("put_b0_data",       {32'd0, out_a_data},   64'h55667788);
      check("put_b0_mask",       {60'd0, out_a_mask},   64'hF);
      check("put_b0_in_a_ready", {63'd0, in_a_ready},   64'd0);
      check("put_b0_addr",       {32'd0, out_a_address}, 64'h100);
      @(negedge clock);
      #1;
      check("put_b1_data",       {32'd0, out_a_data},   64'h11223344);
      check("put_b1_mask",       {60'd0, out_a_mask},   64'hF);
      check("put_b1_in_a_ready", {63'd0, in_a_ready},   64'd1);
      check("put_b1_size",       {60'd0, out_a_size},   64'd3);

      // ---------------- Get size 2 at upper lane ----------------
      @(negedge clock);
      in_a_opcode  = 3'd4;
      in_a_size    = 4'd2;
      in_a_address = 32'h104;
      in_a_mask    = 8'hF0;
      in_a_data    = 64'h0;
      #1;
      check("get_mask",       {60'd0, out_a_mask},    64'hF);
      check("get_addr",       {32'd0, out_a_address}, 64'h104);
      check("get_opcode",     {61'd0, out_a_opcode},  64'd4);
      check("get_in_a_ready", {63'd0, in_a_ready},    64'd1);
      @(negedge clock);
      in_a_valid = 1'b0;
      #1;
      check("a_idle_valid", {63'd0, out_a_valid}, 64'd0);

      // ---------------- AccessAckData size 3 merge ----------------
      drive_d(1'b1, 3'd1, 4'd3, 32'hAAAA0000, 1'b0, 1'b1, 2'd1);
      check("ackd_b0_in_d_valid",  {63'd0, in_d_valid},  64'd0);
      check("ackd_b0_out_d_ready", {63'd0, out_d_ready}, 64'd1);
      drive_d(1'b1, 3'd1, 4'd3, 32'hBBBB1111, 1'b1, 1'b0, 2'd2);
      check("ackd_b1_in_d_valid", {63'd0, in_d_valid},   64'd1);
      check("ackd_b1_data",       in_d_data,             64'hBBBB1111AAAA0000);
      check("ackd_b1_corrupt",    {63'd0, in_d_corrupt}, 64'd1);
      check("ackd_b1_denied",     {63'd0, in_d_denied},  64'd1);
      check("ackd_b1_sink",       {62'd0, in_d_sink},    64'd2);

      // ---------------- AccessAckData size 2 replicated ----------------
      drive_d(1'b1, 3'd1, 4'd2, 32'hDEADBEEF, 1'b0, 1'b0, 2'd0);
      check("ackd_s2_in_d_valid", {63'd0, in_d_valid},   64'd1);
      check("ackd_s2_data",       in_d_data,             64'hDEADBEEFDEADBEEF);
      check("ackd_s2_corrupt",    {63'd0, in_d_corrupt}, 64'd0);
      check("ackd_s2_denied",     {63'd0, in_d_denied},  64'd0);

      // ---------------- upstream backpressure on final beat ----------------
      drive_d(1'b1, 3'd1, 4'd3, 32'h01234567, 1'b0, 1'b0, 2'd0);
      check("bp_b0_in_d_valid", {63'd0, in_d_valid}, 64'd0);
      in_d_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_d(1'b1, 3'd1, 4'd3, 32'h89ABCDEF, 1'b0, 1'b0, 2'd0);
         check("bp_hold_out_d_ready", {63'd0, out_d_ready}, 64'd0);
         check("bp_hold_in_d_valid",  {63'd0, in_d_valid},  64'd1);
         check("bp_hold_data",        in_d_data,            64'h89ABCDEF01234567);
      end
      @(negedge clock);
      in_d_ready = 1'b1;
      #1;
      check("bp_release_out_d_ready", {63'd0, out_d_ready}, 64'd1);
      check("bp_release_data",        in_d_data,            64'h89ABCDEF01234567);
      // Exactly one fire occurred: a plain AccessAck is now a single-beat group.
      drive_d(1'b1, 3'd0, 4'd2, 32'h5A5A5A5A, 1'b0, 1'b0, 2'd0);
      check("bp_after_ack_valid", {63'd0, in_d_valid}, 64'd1);
      check("bp_after_ack_data",  in_d_data,           64'h5A5A5A5A5A5A5A5A);

      // ---------------- reset mid-burst discards partial slice ----------------
      drive_d(1'b1, 3'd1, 4'd3, 32'hCAFEF00D, 1'b1, 1'b1, 2'd0);
      check("rstmid_b0_in_d_valid", {63'd0, in_d_valid}, 64'd0);
      drive_d(1'b0, 3'd1, 4'd3, 32'h0, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      drive_d(1'b1, 3'd1, 4'd3, 32'h11111111, 1'b0, 1'b0, 2'd0);
      check("rstmid_n0_in_d_valid", {63'd0, in_d_valid}, 64'd0);
      drive_d(1'b1, 3'd1, 4'd3, 32'h22222222, 1'b0, 1'b0, 2'd0);
      check("rstmid_n1_in_d_valid", {63'd0, in_d_valid},   64'd1);
      check("rstmid_n1_data",       in_d_data,             64'h2222222211111111);
      check("rstmid_n1_corrupt",    {63'd0, in_d_corrupt}, 64'd0);
      check("rstmid_n1_denied",     {63'd0, in_d_denied},  64'd0);
      drive_d(1'b0, 3'd0, 4'd0, 32'h0, 1'b0, 1'b0, 2'd0);
      check("d_idle_valid", {63'd0, in_d_valid}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
